// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode CSR file: interrupts, traps, counters, cache control
module trap_csr_unit #(
  parameter int NUM_PLAT_IRQ = 4,
  parameter int COUNTER_W    = 64,
  parameter int VECTORED_EN  = 1,
  parameter int NC_REGIONS   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                f3,
  input  logic [31:0]               write_data,
  input  logic                      write_enable,
  input  logic [11:0]               address,
  input  logic [31:0]               current_core_pc,
  input  logic                      instr_retired,
  input  logic                      timer_itr,
  input  logic                      soft_itr,
  input  logic                      ext_itr,
  input  logic [NUM_PLAT_IRQ-1:0]   plat_itr,
  input  logic                      m_ret,
  input  logic                      exception,
  input  logic [30:0]               exception_cause,
  input  logic [31:0]               exception_tval,
  output logic [31:0]               read_data,
  output logic                      trap,
  output logic [31:0]               trap_target_pc,
  output logic [31:0]               mepc_out,
  output logic                      flush_cache_flag,
  output logic [32*NC_REGIONS-1:0]  nc_base_addr,
  output logic [32*NC_REGIONS-1:0]  nc_limit_addr
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTR   = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
  localparam logic [11:0] ADDR_FLUSH    = 12'h7C0;
  localparam int          NC_FIRST      = 'h7C1;

  // Platform lines live at mie/mip bits 16 and up; the three standard lines at 3, 7, 11.
  localparam logic [31:0] PLAT_MASK = ((32'd1 << NUM_PLAT_IRQ) - 32'd1) << 16;
  localparam logic [31:0] MIE_MASK  = PLAT_MASK | 32'h0000_0888;

  logic                 mstatus_mie, mstatus_mpie;
  logic [31:0]          mie_q, mip_q, mip_d, mtvec_q, mscratch_q, mcause_q, mtval_q;
  logic [29:0]          mepc_q;
  logic [1:0]           inhibit_q;  // [0] mcycle, [1] minstret
  logic [COUNTER_W-1:0] mcycle_q, minstret_q;
  logic [63:0]          mcycle64, minstret64;
  logic [63:0]          cyc_lo_wr, cyc_hi_wr, ins_lo_wr, ins_hi_wr;
  logic                 flush_q, trap_taken;
  logic [31:0]          nc_base_q  [NC_REGIONS];
  logic [31:0]          nc_limit_q [NC_REGIONS];
  logic [31:0]          wv, pend, mcause_d, tvec_base;
  logic                 sw_we, irq_eligible;
  logic [4:0]           irq_code;
  logic [1:0]           mtvec_mode_d;
  logic                 unused_bits;

  assign unused_bits = &{1'b0, f3[2], current_core_pc[1:0]};

  assign mcycle64   = 64'(mcycle_q);
  assign minstret64 = 64'(minstret_q);

  // Combinational CSR read mux; unmapped addresses read zero.
  always_comb begin
    read_data = 32'h0;
    case (address)
      ADDR_MSTATUS:  read_data = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MIE:      read_data = mie_q;
      ADDR_MIP:      read_data = mip_q;
      ADDR_MTVEC:    read_data = mtvec_q;
      ADDR_MINHIBIT: read_data = {29'b0, inhibit_q[1], 1'b0, inhibit_q[0]};
      ADDR_MSCRATCH: read_data = mscratch_q;
      ADDR_MEPC:     read_data = {mepc_q, 2'b00};
      ADDR_MCAUSE:   read_data = mcause_q;
      ADDR_MTVAL:    read_data = mtval_q;
      ADDR_MCYCLE:   read_data = mcycle64[31:0];
      ADDR_MCYCLEH:  read_data = mcycle64[63:32];
      ADDR_MINSTR:   read_data = minstret64[31:0];
      ADDR_MINSTRH:  read_data = minstret64[63:32];
      ADDR_FLUSH:    read_data = {31'b0, flush_q};
      default: begin
        for (int i = 0; i < NC_REGIONS; i++) begin
          if (address == 12'(NC_FIRST + 2 * i))     read_data = nc_base_q[i];
          if (address == 12'(NC_FIRST + 2 * i + 1)) read_data = nc_limit_q[i];
        end
      end
    endcase
  end

  // Read-modify-write value for write/set/clear forms.
  always_comb begin
    case (f3[1:0])
      2'b10:   wv = read_data | write_data;
      2'b11:   wv = read_data & ~write_data;
      default: wv = write_data;
    endcase
  end

  // Software writes are discarded whenever a trap is being taken.
  assign sw_we = write_enable & (f3[1:0] != 2'b00) & ~trap;

  assign mip_d = (32'(plat_itr) << 16)
               | {20'b0, ext_itr, 3'b0, timer_itr, 3'b0, soft_itr, 3'b0};
  assign pend         = mip_q & mie_q;
  assign irq_eligible = (pend != 32'h0) & mstatus_mie;
  assign trap         = (irq_eligible | exception) & ~trap_taken;

  // Interrupt code selection: later assignments carry higher priority.
  always_comb begin
    irq_code = 5'd0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (pend[16 + i]) irq_code = 5'(16 + i);
    end
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  assign mcause_d       = irq_eligible ? {1'b1, 26'b0, irq_code} : {1'b0, exception_cause};
  assign tvec_base      = {mtvec_q[31:2], 2'b00};
  assign trap_target_pc = (irq_eligible && mtvec_q[1:0] == 2'b01)
                        ? tvec_base + {25'b0, irq_code, 2'b00} : tvec_base;
  assign mtvec_mode_d   = (VECTORED_EN != 0 && wv[1:0] == 2'b01) ? 2'b01 : 2'b00;

  assign mepc_out         = {mepc_q, 2'b00};
  assign flush_cache_flag = flush_q;

  for (genvar g = 0; g < NC_REGIONS; g++) begin : g_nc
    assign nc_base_addr[32*g +: 32]  = nc_base_q[g];
    assign nc_limit_addr[32*g +: 32] = nc_limit_q[g];
  end

  // Trap-in-progress flag: set on trap, cleared by mret; trap wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      trap_taken <= 1'b0;
    else if (trap)   trap_taken <= 1'b1;
    else if (m_ret)  trap_taken <= 1'b0;
  end

  // mstatus interrupt-enable stack: trap, then mret, then software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (m_ret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (sw_we && address == ADDR_MSTATUS) begin
      mstatus_mie  <= wv[3];
      mstatus_mpie <= wv[7];
    end
  end

  // Trap record registers: hardware capture on trap, otherwise software writable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap) begin
      mepc_q   <= current_core_pc[31:2];
      mcause_q <= mcause_d;
      mtval_q  <= irq_eligible ? 32'h0 : exception_tval;
    end else if (sw_we) begin
      if (address == ADDR_MEPC)   mepc_q   <= wv[31:2];
      if (address == ADDR_MCAUSE) mcause_q <= wv;
      if (address == ADDR_MTVAL)  mtval_q  <= wv;
    end
  end

  // Plain software-owned registers and the interrupt-line sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mip_q      <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      inhibit_q  <= '0;
    end else begin
      mip_q <= mip_d;
      if (sw_we) begin
        if (address == ADDR_MIE)      mie_q      <= wv & MIE_MASK;
        if (address == ADDR_MTVEC)    mtvec_q    <= {wv[31:2], mtvec_mode_d};
        if (address == ADDR_MSCRATCH) mscratch_q <= wv;
        if (address == ADDR_MINHIBIT) inhibit_q  <= {wv[2], wv[0]};
      end
    end
  end

  assign cyc_lo_wr = {mcycle64[63:32], wv};
  assign cyc_hi_wr = {wv, mcycle64[31:0]};
  assign ins_lo_wr = {minstret64[63:32], wv};
  assign ins_hi_wr = {wv, minstret64[31:0]};

  // Free-running counters; a write to either half replaces the whole value for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (sw_we && address == ADDR_MCYCLE)       mcycle_q <= cyc_lo_wr[COUNTER_W-1:0];
      else if (sw_we && address == ADDR_MCYCLEH) mcycle_q <= cyc_hi_wr[COUNTER_W-1:0];
      else if (!inhibit_q[0])                    mcycle_q <= mcycle_q + 1'b1;

      if (sw_we && address == ADDR_MINSTR)       minstret_q <= ins_lo_wr[COUNTER_W-1:0];
      else if (sw_we && address == ADDR_MINSTRH) minstret_q <= ins_hi_wr[COUNTER_W-1:0];
      else if (instr_retired && !inhibit_q[1])   minstret_q <= minstret_q + 1'b1;
    end
  end

  // Flush request self-clears one cycle after being set; the clear beats a new write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   flush_q <= 1'b0;
    else if (flush_q)                             flush_q <= 1'b0;
    else if (sw_we && address == ADDR_FLUSH)      flush_q <= wv[0];
  end

  // Non-cachable window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC_REGIONS; i++) begin
        nc_base_q[i]  <= '0;
        nc_limit_q[i] <= '0;
      end
    end else if (sw_we) begin
      for (int i = 0; i < NC_REGIONS; i++) begin
        if (address == 12'(NC_FIRST + 2 * i))     nc_base_q[i]  <= wv;
        if (address == 12'(NC_FIRST + 2 * i + 1)) nc_limit_q[i] <= wv;
      end
    end
  end

endmodule
